// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ibus/dbus to unified cbus arbiter.
// Revision: 1.0
`default_nettype none

package mem_bus_arbiter_pkg;

  localparam int XLEN = 64;
  localparam logic [2:0] IBUS_SIZE = 3'b010;

  typedef enum logic {
    IBUS = 1'b0,
    DBUS = 1'b1
  } owner_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  addr;
  } ibus_req_t;

  typedef struct packed {
    logic         addr_ok;
    logic         data_ok;
    logic [31:0]  data;
  } ibus_resp_t;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  addr;
    logic [2:0]       size;
    logic [7:0]       strobe;
    logic [XLEN-1:0]  data;
  } dbus_req_t;

  typedef struct packed {
    logic             addr_ok;
    logic             data_ok;
    logic [XLEN-1:0]  data;
  } dbus_resp_t;

  typedef struct packed {
    logic             valid;
    logic             is_write;
    logic [2:0]       size;
    logic [XLEN-1:0]  addr;
    logic [7:0]       strobe;
    logic [XLEN-1:0]  data;
  } cbus_req_t;

  typedef struct packed {
    logic             ready;
    logic [XLEN-1:0]  data;
  } cbus_resp_t;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port (cbus) between ibus and dbus.
// Revision: 1.0
`default_nettype none

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  if (ADDR_W != XLEN || DATA_W != XLEN) begin : g_width_check
    $error("mem_bus_arbiter: ADDR_W and DATA_W must both be 64");
  end

  state_t    state;
  owner_t    owner_q;
  owner_t    last_q;
  cbus_req_t req_q;
  owner_t    winner;
  cbus_req_t grant_req;
  logic      done;

  // On a tie, whoever was not granted last time wins.
  function automatic owner_t pick(input logic iv, input logic dv, input owner_t last);
    if (iv && dv) return (last == DBUS) ? IBUS : DBUS;
    else if (dv)  return DBUS;
    else          return IBUS;
  endfunction

  assign winner = pick(ireq.valid, dreq.valid, last_q);

  always_comb begin
    grant_req       = '0;
    grant_req.valid = 1'b1;
    if (winner == DBUS) begin
      grant_req.is_write = |dreq.strobe;
      grant_req.size     = dreq.size;
      grant_req.addr     = dreq.addr;
      grant_req.strobe   = dreq.strobe;
      grant_req.data     = dreq.data;
    end else begin
      grant_req.size = IBUS_SIZE;
      grant_req.addr = ireq.addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner_q <= IBUS;
      last_q  <= IBUS;
      req_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ireq.valid || dreq.valid) begin
            state   <= BUSY;
            owner_q <= winner;
            last_q  <= winner;
            req_q   <= grant_req;
          end
        end
        BUSY: begin
          if (cresp.ready) begin
            state       <= IDLE;
            req_q.valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign creq = req_q;
  assign done = (state == BUSY) && cresp.ready;

  // A requester that withdrew valid gets no completion; data is zeroed when not acknowledging.
  always_comb begin
    iresp         = '0;
    dresp         = '0;
    iresp.data_ok = done && (owner_q == IBUS) && ireq.valid;
    iresp.addr_ok = iresp.data_ok;
    iresp.data    = !iresp.data_ok ? 32'h0 :
                    req_q.addr[2] ? cresp.data[63:32] : cresp.data[31:0];
    dresp.data_ok = done && (owner_q == DBUS) && dreq.valid;
    dresp.addr_ok = dresp.data_ok;
    dresp.data    = dresp.data_ok ? cresp.data : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with directed vectors.
// Revision: 1.0
`default_nettype none

module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  typedef struct {
    owner_t      side;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .creq  (creq),
    .cresp (cresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ready_pulse(input logic [63:0] d);
    cresp.ready = 1'b1;
    cresp.data  = d;
    step();
    cresp.ready = 1'b0;
    cresp.data  = '0;
  endtask

  task automatic expect_resp(input owner_t s, input logic [63:0] d);
    exp_t e;
    e.side = s;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic set_ireq(input logic v, input logic [63:0] a);
    ireq.valid = v;
    ireq.addr  = a;
  endtask

  task automatic set_dreq(input logic v, input logic [63:0] a, input logic [7:0] strb,
                          input logic [63:0] d);
    dreq.valid  = v;
    dreq.addr   = a;
    dreq.size   = 3'd3;
    dreq.strobe = strb;
    dreq.data   = d;
  endtask

  // Monitor: every acknowledged response must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t   e;
    owner_t side;
    check("addr_ok_eq_data_ok", {62'b0, iresp.addr_ok, dresp.addr_ok},
          {62'b0, iresp.data_ok, dresp.data_ok});
    if (iresp.data_ok || dresp.data_ok) begin
      if (iresp.data_ok && dresp.data_ok) begin
        check("single_data_ok", {62'b0, iresp.data_ok, dresp.data_ok}, 64'h1);
      end else if (exp_q.size() == 0) begin
        check("unexpected_data_ok", {62'b0, iresp.data_ok, dresp.data_ok}, 64'h0);
      end else begin
        e    = exp_q.pop_front();
        side = dresp.data_ok ? DBUS : IBUS;
        check("resp_side", {63'b0, side}, {63'b0, e.side});
        check("resp_data", dresp.data_ok ? dresp.data : {32'b0, iresp.data}, e.data);
      end
    end
  end

  initial begin
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    cresp = '0;
    step(2);
    check("rst_creq_valid", {63'b0, creq.valid}, 64'h0);
    check("rst_iresp", {30'b0, iresp}, 64'h0);
    check("rst_dresp_flags", {62'b0, dresp.addr_ok, dresp.data_ok}, 64'h0);
    check("rst_dresp_data", dresp.data, 64'h0);
    reset = 1'b0;

    // Three ties in a row: dbus, ibus, dbus.
    set_ireq(1'b1, 64'h8000_0010);
    set_dreq(1'b1, 64'h8000_1000, 8'h00, 64'h0);
    step();
    check("tie1_creq_valid", {63'b0, creq.valid}, 64'h1);
    check("tie1_addr", creq.addr, 64'h8000_1000);
    check("tie1_is_write", {63'b0, creq.is_write}, 64'h0);
    expect_resp(DBUS, 64'h1111_2222_3333_4444);
    ready_pulse(64'h1111_2222_3333_4444);
    check("idle_after_ready", {63'b0, creq.valid}, 64'h0);
    dreq.addr = 64'h8000_1008;
    step();
    check("tie2_addr", creq.addr, 64'h8000_0010);
    check("tie2_size", {61'b0, creq.size}, 64'h2);
    expect_resp(IBUS, 64'h7777_8888);
    ready_pulse(64'h5555_6666_7777_8888);
    ireq.addr = 64'h8000_0014;
    step();
    check("tie3_addr", creq.addr, 64'h8000_1008);
    expect_resp(DBUS, 64'h9999_0000_9999_0000);
    ready_pulse(64'h9999_0000_9999_0000);
    dreq.valid = 1'b0;
    step();
    check("ibus_after_tie3_addr", creq.addr, 64'h8000_0014);
    expect_resp(IBUS, 64'h0123_4567);
    ready_pulse(64'h0123_4567_89AB_CDEF);
    ireq.valid = 1'b0;
    step();

    // Fetch with ready three cycles after the request.
    set_ireq(1'b1, 64'h8000_0004);
    step();
    check("fetch_valid", {63'b0, creq.valid}, 64'h1);
    check("fetch_addr", creq.addr, 64'h8000_0004);
    check("fetch_is_write", {63'b0, creq.is_write}, 64'h0);
    check("fetch_size", {61'b0, creq.size}, 64'h2);
    check("fetch_strobe", {56'b0, creq.strobe}, 64'h0);
    step(2);
    check("fetch_still_valid", {63'b0, creq.valid}, 64'h1);
    expect_resp(IBUS, 64'hAAAA_BBBB);
    ready_pulse(64'hAAAA_BBBB_CCCC_DDDD);
    ireq.valid = 1'b0;
    check("fetch_done_valid", {63'b0, creq.valid}, 64'h0);

    // Store; core changes data after grant.
    set_dreq(1'b1, 64'h8000_2000, 8'hFF, 64'h1234);
    step();
    check("store_is_write", {63'b0, creq.is_write}, 64'h1);
    check("store_addr", creq.addr, 64'h8000_2000);
    check("store_strobe", {56'b0, creq.strobe}, 64'hFF);
    check("store_data", creq.data, 64'h1234);
    check("store_size", {61'b0, creq.size}, 64'h3);
    dreq.data = 64'hDEAD;
    step();
    check("store_data_held", creq.data, 64'h1234);
    expect_resp(DBUS, 64'hCAFE);
    ready_pulse(64'hCAFE);
    dreq.valid = 1'b0;
    step();

    // ibus withdraws mid-transaction while a dreq waits.
    set_ireq(1'b1, 64'h8000_0020);
    step();
    ireq.valid = 1'b0;
    set_dreq(1'b1, 64'h8000_3000, 8'h00, 64'h0);
    step();
    check("withdraw_busy_addr", creq.addr, 64'h8000_0020);
    ready_pulse(64'hFFFF_FFFF_FFFF_FFFF);
    check("withdraw_idle", {63'b0, creq.valid}, 64'h0);
    step();
    check("pending_dreq_valid", {63'b0, creq.valid}, 64'h1);
    check("pending_dreq_addr", creq.addr, 64'h8000_3000);
    expect_resp(DBUS, 64'h42);
    ready_pulse(64'h42);
    dreq.valid = 1'b0;
    step();

    // Asynchronous reset while BUSY with ready high.
    set_ireq(1'b1, 64'h8000_0008);
    step();
    cresp.ready = 1'b1;
    cresp.data  = 64'h77;
    #1;
    check("pre_reset_data_ok", {63'b0, iresp.data_ok}, 64'h1);
    reset = 1'b1;
    #1;
    check("async_rst_creq_valid", {63'b0, creq.valid}, 64'h0);
    check("async_rst_data_ok", {63'b0, iresp.data_ok}, 64'h0);
    cresp = '0;
    ireq.valid = 1'b0;
    step();
    reset = 1'b0;
    check("post_rst_idle", {63'b0, creq.valid}, 64'h0);
    set_ireq(1'b1, 64'h8000_0030);
    set_dreq(1'b1, 64'h8000_4000, 8'h00, 64'h0);
    step();
    check("post_rst_tie_addr", creq.addr, 64'h8000_4000);
    expect_resp(DBUS, 64'h55);
    ready_pulse(64'h55);
    dreq.valid = 1'b0;
    step();
    check("post_rst_ibus_addr", creq.addr, 64'h8000_0030);
    expect_resp(IBUS, 64'h6666_7777);
    ready_pulse(64'h1111_0000_6666_7777);
    ireq.valid = 1'b0;
    step();

    // Spurious ready while IDLE.
    ready_pulse(64'h1234);
    check("spurious_idle", {63'b0, creq.valid}, 64'h0);
    step(2);
    check("spurious_still_idle", {63'b0, creq.valid}, 64'h0);

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
